ram_responder: RTL and testbench

Memory-side responder for the RAM region: the slave end of the select/finish memory interface that the access arbiter drives for RAM. It accepts one request at a time (address, write data, width, direction), checks alignment and range, and performs the read or write on an internal synchronous word array after a programmable latency. It returns finish, read data and an exception code to the arbiter.

---
 rtl/ram_responder_pkg.sv | 31 +++
 rtl/ram_byte_array.sv | 27 ++
 rtl/ram_responder.sv | 139 +++++++++++++
 tb/tb_ram_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared memory-interface constants and the request record used by the RAM responder.
// Width/exception encodings must match the arbiter and core that drive this slave.
package ram_responder_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd4;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic        is_read;
    } mem_req_t;

    // Right-aligned byte-lane mask for an access width.
    function automatic logic [3:0] lane_mask(logic [1:0] width);
        case (width)
            MEM_WIDTH_BYTE: return 4'b0001;
            MEM_WIDTH_HALF: return 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Word-organised RAM with per-byte write enables, synchronous write and combinational read.
module ram_byte_array #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [3:0]            wr_be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // NOTE: the array has no reset branch; clearing it would turn the RAM into thousands of flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/ram_responder.sv
// Slave end of the select/finish memory interface for the RAM region: request checking,
// programmable-latency access sequencing and byte-lane alignment around ram_byte_array.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr_In,
    input  logic [31:0]              data_In,
    input  logic [1:0]               dataWidth_In,
    input  logic                     isRead_In,
    input  logic                     select_In,
    output logic                     finish_Out,
    output logic [31:0]              data_Out,
    output logic [EXCEPTION_LEN-1:0] exception_Out
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t   state, state_d;
    logic [3:0] cnt, cnt_d;
    mem_req_t req_in, req_q;
    logic     bad_q, req_bad, misaligned, out_of_range;
    logic     accept, complete, wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data, rd_word, rd_shifted, rd_value, data_d;

    assign req_in = '{addr: addr_In, data: data_In, width: dataWidth_In, is_read: isRead_In};

    assign misaligned   = (dataWidth_In == MEM_WIDTH_HALF && addr_In[0])
                       || (dataWidth_In == MEM_WIDTH_WORD && addr_In[1:0] != 2'b00);
    assign out_of_range = |addr_In[31:ADDR_WIDTH+2];
    assign req_bad      = misaligned | out_of_range;

    always_comb begin
        if (select_In && req_bad)
            exception_Out = isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
        else
            exception_Out = EXCEP_OK;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        accept   = 1'b0;
        complete = 1'b0;
        unique case (state)
            ST_IDLE: accept = select_In;
            ST_WAIT: begin
                if (!select_In) begin
                    state_d = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!select_In) state_d = ST_IDLE;
                else            accept  = (req_in != req_q);
            end
            default: state_d = ST_IDLE;
        endcase
        // Bad requests take a single WAIT cycle and never touch the array.
        if (accept) begin
            state_d = ST_WAIT;
            cnt_d   = req_bad ? 4'd0 : 4'(LATENCY - 1);
        end
    end

    assign wr_en = complete && !bad_q && !req_q.is_read;
    assign wr_be = lane_mask(req_q.width) << req_q.addr[1:0];

    always_comb begin
        case (req_q.width)
            MEM_WIDTH_BYTE: wr_data = {4{req_q.data[7:0]}};
            MEM_WIDTH_HALF: wr_data = {2{req_q.data[15:0]}};
            default:        wr_data = req_q.data;
        endcase
    end

    assign rd_shifted = rd_word >> {req_q.addr[1:0], 3'b000};

    always_comb begin
        case (req_q.width)
            MEM_WIDTH_BYTE: rd_value = {24'd0, rd_shifted[7:0]};
            MEM_WIDTH_HALF: rd_value = {16'd0, rd_shifted[15:0]};
            default:        rd_value = rd_shifted;
        endcase
    end

    always_comb begin
        data_d = data_Out;
        if (complete) begin
            if (bad_q)              data_d = 32'd0;
            else if (req_q.is_read) data_d = rd_value;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            data_Out <= 32'd0;
            req_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            data_Out <= data_d;
            if (accept) begin
                req_q <= req_in;
                bad_q <= req_bad;
            end
        end
    end

    assign finish_Out = (state == ST_DONE);

    ram_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .addr    (req_q.addr[ADDR_WIDTH+1:2]),
        .wr_data (wr_data),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: a byte-array reference model predicts finish timing
// and read data; a monitor compares them whenever finish_Out rises.
module tb_ram_responder;
    import ram_responder_pkg::*;

    localparam int AW   = 12;
    localparam int LAT  = 3;
    localparam int SPAN = 4 << AW;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] addr_In, data_In;
    logic [1:0]  dataWidth_In;
    logic        isRead_In, select_In;
    logic        finish_Out;
    logic [31:0] data_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;

    always #5 clk = ~clk;

    ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk           (clk),
        .rst           (rst),
        .addr_In       (addr_In),
        .data_In       (data_In),
        .dataWidth_In  (dataWidth_In),
        .isRead_In     (isRead_In),
        .select_In     (select_In),
        .finish_Out    (finish_Out),
        .data_Out      (data_Out),
        .exception_Out (exception_Out)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model [0:SPAN-1];
    logic [31:0] last_data = 32'd0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a request and record what the responder must eventually return.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] w, input logic rd);
        int   sz;
        logic bad;
        logic [31:0] v;
        exp_t e;
        sz  = 1 << w;
        bad = (a % sz != 0) || (a >= 32'(SPAN));
        addr_In = a; data_In = d; dataWidth_In = w; isRead_In = rd; select_In = 1'b1;
        e.cyc = cyc + 1 + (bad ? 1 : LAT);
        if (bad) begin
            last_data = 32'd0;
        end else if (rd) begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v |= 32'(model[a + i]) << (8 * i);
            last_data = v;
        end else begin
            for (int i = 0; i < sz; i++) model[a + i] = d[8*i +: 8];
        end
        e.data = last_data;
        exp_q.push_back(e);
        #1;
        check("exception", exception_Out,
              bad ? (rd ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE) : EXCEP_OK);
    endtask

    task automatic wait_finish(input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (finish_Out) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: finish_Out stayed 0, want 1 within 40 cycles", name);
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] w, input logic rd);
        @(negedge clk);
        drive_req(a, d, w, rd);
        wait_finish("request_finish");
        @(negedge clk);
        select_In = 1'b0;
    endtask

    // Monitor: every rising finish_Out consumes one scoreboard entry.
    logic prev_fin = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (finish_Out && !prev_fin) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_finish: got finish with data %h, want no finish", data_Out);
            end else begin
                e = exp_q.pop_front();
                check("finish_cycle", cyc, e.cyc);
                check("data_Out", data_Out, e.data);
            end
        end
        prev_fin = finish_Out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; select_In = 1'b0; addr_In = '0; data_In = '0;
        dataWidth_In = MEM_WIDTH_WORD; isRead_In = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_finish", finish_Out, 1'b0);
        check("reset_data", data_Out, 32'd0);
        addr_In = 32'h0001_0001;
        #1 check("exception_unselected", exception_Out, EXCEP_OK);

        for (int i = 0; i < 64; i += 4)        request(i, $urandom, MEM_WIDTH_WORD, 1'b0);
        for (int i = SPAN - 16; i < SPAN; i += 4) request(i, $urandom, MEM_WIDTH_WORD, 1'b0);

        request(32'h10, 32'hDEAD_BEEF, MEM_WIDTH_WORD, 1'b0);
        request(32'h10, 32'h0,         MEM_WIDTH_WORD, 1'b1);
        request(32'h13, 32'h5A,        MEM_WIDTH_BYTE, 1'b0);
        request(32'h10, 32'h0,         MEM_WIDTH_WORD, 1'b1);
        request(32'h12, 32'h0,         MEM_WIDTH_HALF, 1'b1);
        request(32'h11, 32'h0,         MEM_WIDTH_HALF, 1'b1);
        request(32'h10, 32'h0,         MEM_WIDTH_WORD, 1'b1);
        request(32'h0001_0000, 32'hCAFE_F00D, MEM_WIDTH_WORD, 1'b0);
        request(32'h3FFC, 32'h0, MEM_WIDTH_WORD, 1'b1);

        // Abort a write one cycle after acceptance: nothing may complete or commit.
        @(negedge clk);
        addr_In = 32'h20; data_In = 32'h1122_3344; dataWidth_In = MEM_WIDTH_WORD;
        isRead_In = 1'b0; select_In = 1'b1;
        @(negedge clk);
        select_In = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            check("abort_no_finish", finish_Out, 1'b0);
        end
        request(32'h20, 32'h0, MEM_WIDTH_WORD, 1'b1);

        // Back-to-back requests with select held high.
        @(negedge clk);
        drive_req(32'h10, 32'h0, MEM_WIDTH_WORD, 1'b1);
        wait_finish("rearm_first");
        drive_req(32'h14, 32'h0, MEM_WIDTH_WORD, 1'b1);
        @(negedge clk);
        check("rearm_finish_low", finish_Out, 1'b0);
        wait_finish("rearm_second");
        @(negedge clk);
        select_In = 1'b0;

        // Reset in the middle of a pending write drops it.
        @(negedge clk);
        addr_In = 32'h24; data_In = 32'hA5A5_5A5A; dataWidth_In = MEM_WIDTH_WORD;
        isRead_In = 1'b0; select_In = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midwait_reset_finish", finish_Out, 1'b0);
        check("midwait_reset_data", data_Out, 32'd0);
        rst = 1'b0; select_In = 1'b0;
        last_data = 32'd0;
        request(32'h24, 32'h0, MEM_WIDTH_WORD, 1'b1);

        repeat (80) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 63));
                3:       a = 32'(SPAN - 16) + 32'($urandom_range(0, 15));
                4:       a = 32'(SPAN) + 32'($urandom_range(0, 255));
                default: a = $urandom | 32'h0001_0000;
            endcase
            request(a, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
